// File: rtl/mem_write_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_write_checker_pkg : state encodings shared by the write checker
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_write_checker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_IDLE    = 3'd0;
  localparam state_t c_RUN     = 3'd1;
  localparam state_t c_PASS    = 3'd2;
  localparam state_t c_FAIL    = 3'd3;
  localparam state_t c_TIMEOUT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mem_write_checker_entry_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_write_checker_entry_match : bus vs. expected-table compare with priority
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_write_checker_entry_match #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int IDXBITS = 2,
  parameter int ORDERED = 1
) (
  input  logic [WIDTH-1:0]            i_adr,
  input  logic [WIDTH-1:0]            i_data,
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [DEPTH-1:0]            i_matched,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_tab_adr,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_tab_data,
  output logic                        o_hit,
  output logic [IDXBITS-1:0]          o_hit_idx
);

  logic w_taken;

  // Ordered mode locks onto the first pending entry whether or not it matches;
  // unordered mode takes the first pending entry that matches.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_idx = '0;
    w_taken   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_valid[i] && !i_matched[i] && !w_taken) begin
        if (ORDERED != 0) begin
          w_taken   = 1'b1;
          o_hit     = (i_tab_adr[i] == i_adr) && (i_tab_data[i] == i_data);
          o_hit_idx = IDXBITS'(i);
        end else if ((i_tab_adr[i] == i_adr) && (i_tab_data[i] == i_data)) begin
          w_taken   = 1'b1;
          o_hit     = 1'b1;
          o_hit_idx = IDXBITS'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_write_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_write_checker : self-checking monitor of the memory write bus
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int IDXBITS = 2,
  parameter int CNTBITS = 16,
  parameter int TIMEOUT = 250,
  parameter int ORDERED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memwrite,
  input  logic [WIDTH-1:0]   adr,
  input  logic [WIDTH-1:0]   writedata,
  input  logic               exp_load,
  input  logic [IDXBITS-1:0] exp_idx,
  input  logic [WIDTH-1:0]   exp_adr,
  input  logic [WIDTH-1:0]   exp_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [IDXBITS:0]   match_cnt,
  output logic [WIDTH-1:0]   err_adr,
  output logic [WIDTH-1:0]   err_data,
  output logic [CNTBITS-1:0] cycle_cnt
);

  localparam logic [CNTBITS-1:0] c_CNT_LAST = CNTBITS'(TIMEOUT - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            r_matched;
  logic [DEPTH-1:0][WIDTH-1:0] r_tab_adr;
  logic [DEPTH-1:0][WIDTH-1:0] r_tab_data;
  logic [IDXBITS:0]            r_match_cnt;
  logic [CNTBITS-1:0]          r_cycle_cnt;
  logic [WIDTH-1:0]            r_err_adr;
  logic [WIDTH-1:0]            r_err_data;

  logic                        w_hit;
  logic [IDXBITS-1:0]          w_hit_idx;
  logic [DEPTH-1:0]            w_hit_vec;
  logic                        w_armable;
  logic                        w_start_ok;
  logic                        w_load_ok;
  logic                        w_empty;
  logic                        w_final;

  mem_write_checker_entry_match #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .IDXBITS (IDXBITS),
    .ORDERED (ORDERED)
  ) u_match (
    .i_adr      (adr),
    .i_data     (writedata),
    .i_valid    (r_valid),
    .i_matched  (r_matched),
    .i_tab_adr  (r_tab_adr),
    .i_tab_data (r_tab_data),
    .o_hit      (w_hit),
    .o_hit_idx  (w_hit_idx)
  );

  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit_vec[i] = w_hit && (int'(w_hit_idx) == i);
    end
  end

  assign w_armable  = (r_state != c_RUN);
  assign w_start_ok = start && w_armable;
  assign w_load_ok  = exp_load && w_armable && (int'(exp_idx) < DEPTH);
  assign w_empty    = (r_valid == '0);
  assign w_final    = w_hit && ((r_valid & ~r_matched & ~w_hit_vec) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Write decisions are checked before the timeout so a deciding write wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_PASS, c_FAIL, c_TIMEOUT: begin
        if (start) w_next = c_RUN;
      end
      c_RUN: begin
        if (w_empty) begin
          w_next = c_PASS;
        end else if (memwrite) begin
          if (!w_hit)      w_next = c_FAIL;
          else if (w_final) w_next = c_PASS;
        end else if (r_cycle_cnt >= c_CNT_LAST) begin
          w_next = c_TIMEOUT;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == c_RUN);
    pass    = (r_state == c_PASS);
    fail    = (r_state == c_FAIL);
    timeout = (r_state == c_TIMEOUT);
    done    = pass || fail || timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_matched   <= '0;
      r_tab_adr   <= '0;
      r_tab_data  <= '0;
      r_match_cnt <= '0;
      r_cycle_cnt <= '0;
      r_err_adr   <= '0;
      r_err_data  <= '0;
    end else begin
      if (w_load_ok) begin
        r_valid[exp_idx]    <= 1'b1;
        r_tab_adr[exp_idx]  <= exp_adr;
        r_tab_data[exp_idx] <= exp_data;
      end
      if (w_start_ok) begin
        r_matched   <= '0;
        r_match_cnt <= '0;
        r_cycle_cnt <= '0;
        r_err_adr   <= '0;
        r_err_data  <= '0;
      end else if (r_state == c_RUN) begin
        r_cycle_cnt <= r_cycle_cnt + CNTBITS'(1);
        if (memwrite && !w_empty) begin
          if (w_hit) begin
            r_matched   <= r_matched | w_hit_vec;
            r_match_cnt <= r_match_cnt + (IDXBITS + 1)'(1);
          end else begin
            r_err_adr  <= adr;
            r_err_data <= writedata;
          end
        end
      end
    end
  end

  assign match_cnt = r_match_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign err_adr   = r_err_adr;
  assign err_data  = r_err_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_write_checker : directed bench, ordered and unordered checker side by side
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_write_checker;

  localparam int W = 32;
  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_RUN  = 5'b10000;
  localparam logic [4:0] ST_PASS = 5'b01100;
  localparam logic [4:0] ST_FAIL = 5'b01010;
  localparam logic [4:0] ST_TMO  = 5'b01001;

  logic         clk = 1'b0;
  logic         reset, memwrite, exp_load, start;
  logic [W-1:0] adr, writedata, exp_adr, exp_data;
  logic [1:0]   exp_idx;

  logic         busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [2:0]   match_o;
  logic [W-1:0] err_adr_o, err_data_o;
  logic [15:0]  cyc_o;
  logic         busy_u, done_u, pass_u, fail_u, timeout_u;
  logic [2:0]   match_u;
  logic [W-1:0] err_adr_u, err_data_u;
  logic [15:0]  cyc_u;

  wire [4:0] st_o = {busy_o, done_o, pass_o, fail_o, timeout_o};
  wire [4:0] st_u = {busy_u, done_u, pass_u, fail_u, timeout_u};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.ORDERED(1)) dut_o (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .exp_load(exp_load), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .start(start), .busy(busy_o), .done(done_o), .pass(pass_o), .fail(fail_o),
    .timeout(timeout_o), .match_cnt(match_o), .err_adr(err_adr_o),
    .err_data(err_data_o), .cycle_cnt(cyc_o)
  );

  mem_write_checker #(.ORDERED(0)) dut_u (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .exp_load(exp_load), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .start(start), .busy(busy_u), .done(done_u), .pass(pass_u), .fail(fail_u),
    .timeout(timeout_u), .match_cnt(match_u), .err_adr(err_adr_u),
    .err_data(err_data_u), .cycle_cnt(cyc_u)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] i, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_load = 1'b1; exp_idx = i; exp_adr = a; exp_data = d;
    tick();
    exp_load = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (st_o !== ST_IDLE) begin failures++; $display("FAIL reset_status_o got=%b exp=%b", st_o, ST_IDLE); end
    checks++; if (st_u !== ST_IDLE) begin failures++; $display("FAIL reset_status_u got=%b exp=%b", st_u, ST_IDLE); end
    checks++; if ({match_o, cyc_o, err_adr_o, err_data_o} !== '0) begin failures++; $display("FAIL reset_counters got=%0h exp=0", {match_o, cyc_o, err_adr_o, err_data_o}); end
  endtask

  task automatic test_single_pass;
    do_reset();
    load(2'd0, 32'd255, 32'd210);
    go();
    checks++; if (st_o !== ST_RUN || cyc_o !== 16'd0) begin failures++; $display("FAIL pass_armed got=%b/%0d exp=%b/0", st_o, cyc_o, ST_RUN); end
    repeat (5) tick();
    wr(32'd255, 32'd210);
    checks++; if (st_o !== ST_PASS) begin failures++; $display("FAIL pass_status got=%b exp=%b", st_o, ST_PASS); end
    checks++; if (match_o !== 3'd1) begin failures++; $display("FAIL pass_match_cnt got=%0d exp=1", match_o); end
    checks++; if (cyc_o !== 16'd6) begin failures++; $display("FAIL pass_cycle_cnt got=%0d exp=6", cyc_o); end
    repeat (3) tick();
    checks++; if (st_o !== ST_PASS || cyc_o !== 16'd6) begin failures++; $display("FAIL pass_hold got=%b/%0d exp=%b/6", st_o, cyc_o, ST_PASS); end
  endtask

  task automatic test_miss;
    do_reset();
    load(2'd0, 32'd255, 32'd210);
    go();
    wr(32'd255, 32'd7);
    checks++; if (st_o !== ST_FAIL) begin failures++; $display("FAIL miss_status got=%b exp=%b", st_o, ST_FAIL); end
    checks++; if (err_adr_o !== 32'd255 || err_data_o !== 32'd7) begin failures++; $display("FAIL miss_err got=%0d:%0d exp=255:7", err_adr_o, err_data_o); end
    checks++; if (cyc_o !== 16'd1 || match_o !== 3'd0) begin failures++; $display("FAIL miss_counts got=%0d/%0d exp=1/0", cyc_o, match_o); end
    wr(32'd255, 32'd210);
    checks++; if (st_o !== ST_FAIL || match_o !== 3'd0) begin failures++; $display("FAIL miss_hold got=%b/%0d exp=%b/0", st_o, match_o, ST_FAIL); end
  endtask

  task automatic test_ordering;
    do_reset();
    load(2'd0, 32'd0, 32'd1);
    load(2'd1, 32'd4, 32'd2);
    go();
    wr(32'd4, 32'd2);
    checks++; if (st_o !== ST_FAIL || err_adr_o !== 32'd4 || err_data_o !== 32'd2) begin failures++; $display("FAIL ord_out_of_order got=%b %0d:%0d exp=%b 4:2", st_o, err_adr_o, err_data_o, ST_FAIL); end
    checks++; if (st_u !== ST_RUN || match_u !== 3'd1) begin failures++; $display("FAIL unord_first got=%b/%0d exp=%b/1", st_u, match_u, ST_RUN); end
    wr(32'd0, 32'd1);
    checks++; if (st_u !== ST_PASS || match_u !== 3'd2) begin failures++; $display("FAIL unord_pass got=%b/%0d exp=%b/2", st_u, match_u, ST_PASS); end
    go();
    wr(32'd0, 32'd1);
    checks++; if (st_o !== ST_RUN || match_o !== 3'd1) begin failures++; $display("FAIL ord_first got=%b/%0d exp=%b/1", st_o, match_o, ST_RUN); end
    wr(32'd4, 32'd2);
    checks++; if (st_o !== ST_PASS || match_o !== 3'd2) begin failures++; $display("FAIL ord_pass got=%b/%0d exp=%b/2", st_o, match_o, ST_PASS); end
    // Duplicate entries each need their own write.
    do_reset();
    load(2'd0, 32'd8, 32'd8);
    load(2'd2, 32'd8, 32'd8);
    go();
    wr(32'd8, 32'd8);
    checks++; if (st_u !== ST_RUN || match_u !== 3'd1) begin failures++; $display("FAIL unord_dup_first got=%b/%0d exp=%b/1", st_u, match_u, ST_RUN); end
    wr(32'd8, 32'd8);
    checks++; if (st_u !== ST_PASS || match_u !== 3'd2) begin failures++; $display("FAIL unord_dup_pass got=%b/%0d exp=%b/2", st_u, match_u, ST_PASS); end
  endtask

  task automatic test_timeout;
    do_reset();
    load(2'd0, 32'd255, 32'd210);
    go();
    repeat (249) tick();
    checks++; if (st_o !== ST_RUN || cyc_o !== 16'd249) begin failures++; $display("FAIL tmo_before got=%b/%0d exp=%b/249", st_o, cyc_o, ST_RUN); end
    tick();
    checks++; if (st_o !== ST_TMO || cyc_o !== 16'd250) begin failures++; $display("FAIL tmo_edge got=%b/%0d exp=%b/250", st_o, cyc_o, ST_TMO); end
    repeat (4) tick();
    checks++; if (st_o !== ST_TMO || cyc_o !== 16'd250) begin failures++; $display("FAIL tmo_hold got=%b/%0d exp=%b/250", st_o, cyc_o, ST_TMO); end
    go();
    repeat (249) tick();
    wr(32'd255, 32'd210);
    checks++; if (st_o !== ST_PASS || cyc_o !== 16'd250 || match_o !== 3'd1) begin failures++; $display("FAIL tmo_final_hit got=%b/%0d/%0d exp=%b/250/1", st_o, cyc_o, match_o, ST_PASS); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    load(2'd0, 32'd1, 32'd1);
    load(2'd1, 32'd2, 32'd2);
    go();
    wr(32'd1, 32'd1);
    checks++; if (st_o !== ST_RUN || match_o !== 3'd1) begin failures++; $display("FAIL mid_first_hit got=%b/%0d exp=%b/1", st_o, match_o, ST_RUN); end
    do_reset();
    checks++; if (st_o !== ST_IDLE || {match_o, cyc_o, err_adr_o, err_data_o} !== '0) begin failures++; $display("FAIL mid_reset got=%b/%0h exp=%b/0", st_o, {match_o, cyc_o}, ST_IDLE); end
    go();
    checks++; if (st_o !== ST_RUN) begin failures++; $display("FAIL empty_armed got=%b exp=%b", st_o, ST_RUN); end
    tick();
    checks++; if (st_o !== ST_PASS || cyc_o !== 16'd1 || match_o !== 3'd0) begin failures++; $display("FAIL empty_pass got=%b/%0d/%0d exp=%b/1/0", st_o, cyc_o, match_o, ST_PASS); end
  endtask

  task automatic test_rerun;
    do_reset();
    load(2'd0, 32'd255, 32'd210);
    go();
    load(2'd1, 32'd9, 32'd9);
    wr(32'd255, 32'd210);
    checks++; if (st_o !== ST_PASS || match_o !== 3'd1) begin failures++; $display("FAIL load_in_run got=%b/%0d exp=%b/1", st_o, match_o, ST_PASS); end
    go();
    checks++; if (st_o !== ST_RUN || cyc_o !== 16'd0 || match_o !== 3'd0) begin failures++; $display("FAIL rerun_clear got=%b/%0d/%0d exp=%b/0/0", st_o, cyc_o, match_o, ST_RUN); end
    repeat (2) tick();
    go();
    checks++; if (st_o !== ST_RUN || cyc_o !== 16'd3) begin failures++; $display("FAIL start_in_run got=%b/%0d exp=%b/3", st_o, cyc_o, ST_RUN); end
    wr(32'd255, 32'd210);
    checks++; if (st_o !== ST_PASS || match_o !== 3'd1 || cyc_o !== 16'd4) begin failures++; $display("FAIL rerun_pass got=%b/%0d/%0d exp=%b/1/4", st_o, match_o, cyc_o, ST_PASS); end
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; exp_load = 1'b0; start = 1'b0;
    adr = '0; writedata = '0; exp_adr = '0; exp_data = '0; exp_idx = '0;
    test_reset();
    test_single_pass();
    test_miss();
    test_ordering();
    test_timeout();
    test_reset_mid_run();
    test_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
